axi_lite_master_arb: RTL

Two-requester AXI4-Lite master that shares one AXI-Lite slave port (e.g. `axi_lite_slave_basic` register block of the ANN core) between two internal clients, such as the host-config sequencer and the weight loader. Each client issues single-beat read/write commands over a simple REQ/ACK interface. The block arbitrates round-robin, drives the full AXI-Lite handshake, and returns read data and response code.

---
 rtl/axi_lite_defs_pkg.sv | 21 ++
 rtl/rr_arbiter_2.sv | 20 ++
 rtl/axi_lite_master_arb.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_defs_pkg.sv
// Shared definitions for the two-client AXI-Lite master: FSM encodings, response codes, default widths.
package axi_lite_defs;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_DONE         = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter, purely combinational, no backpressure of its own.
// A tie goes to the client that was not granted last; the last-grant register lives in the caller.
module rr_arbiter_2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic       o_grant_valid,
  output logic       o_grant_idx
);

  always_comb begin
    o_grant_valid = i_enable & (|i_req);
    o_grant_idx   = 1'b0;
    if (i_req == 2'b10)
      o_grant_idx = 1'b1;
    else if (i_req == 2'b11)
      o_grant_idx = ~i_last_grant;
  end

endmodule

// File: rtl/axi_lite_master_arb.sv
// Round-robin shares one AXI-Lite slave port between two REQ/ACK clients; all outputs registered.
// Zero-wait slave: ACK three edges after REQ is sampled; any slave READY/VALID stall waits indefinitely.
module axi_lite_master_arb
  import axi_lite_defs::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETn,

  input  logic              R0_REQ,
  input  logic              R0_WE,
  input  logic [ADDR_W-1:0] R0_ADDR,
  input  logic [DATA_W-1:0] R0_WDATA,
  output logic              R0_ACK,
  output logic [DATA_W-1:0] R0_RDATA,
  output logic [1:0]        R0_RESP,

  input  logic              R1_REQ,
  input  logic              R1_WE,
  input  logic [ADDR_W-1:0] R1_ADDR,
  input  logic [DATA_W-1:0] R1_WDATA,
  output logic              R1_ACK,
  output logic [DATA_W-1:0] R1_RDATA,
  output logic [1:0]        R1_RESP,

  output logic              GRANT,
  output logic              BUSY,

  output logic [ADDR_W-1:0] M_AWADDR,
  output logic              M_AWVALID,
  input  logic              M_AWREADY,
  output logic [DATA_W-1:0] M_WDATA,
  output logic              M_WVALID,
  input  logic              M_WREADY,
  input  logic [1:0]        M_BRESP,
  input  logic              M_BVALID,
  output logic              M_BREADY,
  output logic [ADDR_W-1:0] M_ARADDR,
  output logic              M_ARVALID,
  input  logic              M_ARREADY,
  input  logic [DATA_W-1:0] M_RDATA,
  input  logic [1:0]        M_RRESP,
  input  logic              M_RVALID,
  output logic              M_RREADY
);

  state_t              r_state;
  logic                r_last_grant;
  logic                r_grant;
  logic                r_busy;
  logic                r_aw_done;
  logic                r_w_done;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [ADDR_W-1:0]   r_araddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic [1:0]          r_resp0;
  logic [1:0]          r_resp1;

  logic                w_grant_valid;
  logic                w_grant_idx;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_aw_hs;
  logic                w_w_hs;

  rr_arbiter_2 u_arb (
    .i_req         ({R1_REQ, R0_REQ}),
    .i_last_grant  (r_last_grant),
    .i_enable      (r_state == ST_IDLE),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_sel_we    = w_grant_idx ? R1_WE    : R0_WE;
  assign w_sel_addr  = w_grant_idx ? R1_ADDR  : R0_ADDR;
  assign w_sel_wdata = w_grant_idx ? R1_WDATA : R0_WDATA;

  assign w_aw_hs = r_awvalid & M_AWREADY;
  assign w_w_hs  = r_wvalid  & M_WREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_busy       <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_wdata      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_resp0      <= RESP_OKAY;
      r_resp1      <= RESP_OKAY;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_grant      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_busy       <= 1'b1;
            if (w_sel_we) begin
              r_awaddr  <= w_sel_addr;
              r_wdata   <= w_sel_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR_ADDR_DATA;
            end else begin
              r_araddr  <= w_sel_addr;
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end
        end

        // AW and W channels complete independently, possibly on the same edge.
        ST_WR_ADDR_DATA: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (M_BVALID) begin
            r_bready <= 1'b0;
            if (r_grant) begin
              r_resp1 <= M_BRESP;
              r_ack1  <= 1'b1;
            end else begin
              r_resp0 <= M_BRESP;
              r_ack0  <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end

        ST_RD_ADDR: begin
          if (M_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (M_RVALID) begin
            r_rready <= 1'b0;
            if (r_grant) begin
              r_rdata1 <= M_RDATA;
              r_resp1  <= M_RRESP;
              r_ack1   <= 1'b1;
            end else begin
              r_rdata0 <= M_RDATA;
              r_resp0  <= M_RRESP;
              r_ack0   <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end

        // ACK is high for this one cycle; REQ is ignored until back in IDLE.
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign R0_ACK    = r_ack0;
  assign R1_ACK    = r_ack1;
  assign R0_RDATA  = r_rdata0;
  assign R1_RDATA  = r_rdata1;
  assign R0_RESP   = r_resp0;
  assign R1_RESP   = r_resp1;
  assign GRANT     = r_grant;
  assign BUSY      = r_busy;
  assign M_AWADDR  = r_awaddr;
  assign M_AWVALID = r_awvalid;
  assign M_WDATA   = r_wdata;
  assign M_WVALID  = r_wvalid;
  assign M_BREADY  = r_bready;
  assign M_ARADDR  = r_araddr;
  assign M_ARVALID = r_arvalid;
  assign M_RREADY  = r_rready;

endmodule
